// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, fifo_wr_arbiter and the async_fifo write side.
// master: the arbiter; slave: requesters plus the FIFO full flag.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
);
    localparam int GIDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [GIDW-1:0]       grant_id;
    logic [CNTW-1:0]       wr_count;

    modport master (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, grant_id, wr_count
    );

    modport slave (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, grant_id, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NREQ requesters (write clock domain).
// Packet locking is compiled in when the macro ARB_PKT_LOCK_EN is defined.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.master bus
);
    localparam int GIDW = $clog2(NREQ);

    logic [GIDW-1:0]  rr_ptr_r;
    logic             winc_r;
    logic [DSIZE-1:0] wdata_r;
    logic [GIDW-1:0]  grant_id_r;
    logic [CNTW-1:0]  wr_count_r;

    logic [NREQ-1:0]  eligible_s;
    logic [GIDW:0]    idx_s;
    logic             found_s;
    logic [GIDW-1:0]  win_id_s;
    logic [DSIZE-1:0] win_data_s;
    logic             can_load_s;
    logic             drain_s;
    logic             accept_s;
    logic             advance_s;
    logic [GIDW-1:0]  next_ptr_s;
    logic [NREQ-1:0]  req_ready_s;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t     lock_state_r;
    logic [GIDW-1:0] lock_id_r;

    // While a packet is open only its owner may compete.
    always_comb begin
        eligible_s = bus.req_valid;
        if (lock_state_r == LOCKED) begin
            eligible_s = bus.req_valid & (NREQ'(1) << lock_id_r);
        end else begin
            eligible_s = bus.req_valid;
        end
    end

    // The pointer moves only when a packet closes, so a packet never loses its turn.
    assign advance_s = accept_s && bus.req_last[win_id_s];

    // Packet lock FSM.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            lock_state_r <= IDLE;
            lock_id_r    <= {GIDW{1'b0}};
        end else begin
            case (lock_state_r)
                IDLE: begin
                    if (accept_s && !bus.req_last[win_id_s]) begin
                        lock_state_r <= LOCKED;
                        lock_id_r    <= win_id_s;
                    end else begin
                        lock_state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (accept_s && bus.req_last[win_id_s]) begin
                        lock_state_r <= IDLE;
                    end else begin
                        lock_state_r <= LOCKED;
                    end
                end
                default: begin
                    lock_state_r <= IDLE;
                end
            endcase
        end
    end
`else
    logic unused_last_s;

    assign eligible_s    = bus.req_valid;
    assign advance_s     = accept_s;
    assign unused_last_s = ^bus.req_last;
`endif

    // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found_s  = 1'b0;
        win_id_s = {GIDW{1'b0}};
        idx_s    = {(GIDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (GIDW+1)'(k);
            if (idx_s >= (GIDW+1)'(NREQ)) begin
                idx_s = idx_s - (GIDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && eligible_s[idx_s[GIDW-1:0]]) begin
                found_s  = 1'b1;
                win_id_s = idx_s[GIDW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign win_data_s  = bus.req_data[win_id_s*DSIZE +: DSIZE];
    assign can_load_s  = !winc_r || !bus.wfull;
    assign drain_s     = winc_r && !bus.wfull;
    assign accept_s    = found_s && can_load_s && !wrst;
    assign req_ready_s = accept_s ? (NREQ'(1) << win_id_s) : {NREQ{1'b0}};
    assign next_ptr_s  = (win_id_s == GIDW'(NREQ-1)) ? {GIDW{1'b0}} : win_id_s + GIDW'(1);

    // Output slot, drain counter and round-robin pointer.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            winc_r     <= 1'b0;
            wdata_r    <= {DSIZE{1'b0}};
            grant_id_r <= {GIDW{1'b0}};
            wr_count_r <= {CNTW{1'b0}};
            rr_ptr_r   <= {GIDW{1'b0}};
        end else begin
            if (accept_s) begin
                winc_r     <= 1'b1;
                wdata_r    <= win_data_s;
                grant_id_r <= win_id_s;
            end else if (drain_s) begin
                winc_r     <= 1'b0;
            end else begin
                winc_r     <= winc_r;
            end
            if (drain_s) begin
                wr_count_r <= wr_count_r + CNTW'(1);
            end else begin
                wr_count_r <= wr_count_r;
            end
            if (advance_s) begin
                rr_ptr_r <= next_ptr_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.winc      = winc_r;
    assign bus.wdata     = wdata_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.wr_count  = wr_count_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a reference model.
// Build with or without ARB_PKT_LOCK_EN; expectations follow the macro.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int CNTW  = 16;
`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .CNTW(CNTW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .CNTW(CNTW)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.master)
    );

    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.req_data  = 32'h13121110;
        bus.wfull     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_run++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
            n_run++; if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b expected 0", bus.winc); end
            n_run++; if (bus.wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.wr_count); end
            n_run++; if (bus.grant_id !== 2'd0 || bus.wdata !== 8'h00) begin n_fail++; $display("FAIL reset_slot: got id %0d data %h expected 0/00", bus.grant_id, bus.wdata); end
        end
    endtask

    task automatic test_fairness();
        wrst = 1'b0;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_run++; if (bus.winc !== 1'b1) begin n_fail++; $display("FAIL fair_winc[%0d]: got %b expected 1", k, bus.winc); end
            n_run++; if (bus.grant_id !== 2'(k % 4)) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, bus.grant_id, k % 4); end
            n_run++; if (bus.wdata !== 8'(8'h10 + k % 4)) begin n_fail++; $display("FAIL fair_data[%0d]: got %h expected %h", k, bus.wdata, 8'h10 + k % 4); end
        end
        bus.req_valid = 4'h0;
        tick();
        exp_cnt = 8;
        n_run++; if (bus.wr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL fair_count: got %0d expected %0d", bus.wr_count, exp_cnt); end
        n_run++; if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got %b expected 0", bus.winc); end
    endtask

    task automatic test_backpressure();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: DSIZE] = 8'hA5;
        tick();
        n_run++; if (bus.winc !== 1'b1 || bus.wdata !== 8'hA5) begin n_fail++; $display("FAIL bp_load: got winc %b data %h expected 1/a5", bus.winc, bus.wdata); end
        bus.wfull = 1'b1;
        bus.req_valid = 4'b0010;
        bus.req_data[DSIZE +: DSIZE] = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_run++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, bus.req_ready); end
            tick();
            n_run++; if (bus.winc !== 1'b1 || bus.wdata !== 8'hA5 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold[%0d]: got winc %b data %h id %0d expected 1/a5/0", c, bus.winc, bus.wdata, bus.grant_id); end
            n_run++; if (bus.wr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected %0d", c, bus.wr_count, exp_cnt); end
        end
        bus.wfull = 1'b0;
        #1;
        n_run++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", bus.req_ready); end
        tick();
        exp_cnt++;
        n_run++; if (bus.wr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", bus.wr_count, exp_cnt); end
        n_run++; if (bus.winc !== 1'b1 || bus.wdata !== 8'h5A || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL bp_b2b: got winc %b data %h id %0d expected 1/5a/1", bus.winc, bus.wdata, bus.grant_id); end
        bus.req_valid = 4'h0;
        tick();
        exp_cnt++;
        n_run++; if (bus.winc !== 1'b0 || bus.wr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_end: got winc %b count %0d expected 0/%0d", bus.winc, bus.wr_count, exp_cnt); end
    endtask

    task automatic test_sparse();
        bus.req_valid = 4'b0100;
        bus.req_data[2*DSIZE +: DSIZE] = 8'h3C;
        #1;
        n_run++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL sparse_ready: got %b expected 0100", bus.req_ready); end
        tick();
        n_run++; if (bus.winc !== 1'b1 || bus.wdata !== 8'h3C || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL sparse_slot: got winc %b data %h id %0d expected 1/3c/2", bus.winc, bus.wdata, bus.grant_id); end
        bus.req_valid = 4'hF;
        #1;
        n_run++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_rrptr: got %b expected 1000", bus.req_ready); end
        tick();
        exp_cnt++;
        n_run++; if (bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL sparse_next: got %0d expected 3", bus.grant_id); end
        bus.req_valid = 4'h0;
        tick();
        exp_cnt++;
        n_run++; if (bus.wr_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sparse_count: got %0d expected %0d", bus.wr_count, exp_cnt); end
    endtask

    task automatic test_midop_reset();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: DSIZE] = 8'h77;
        tick();
        n_run++; if (bus.winc !== 1'b1) begin n_fail++; $display("FAIL mid_load: got %b expected 1", bus.winc); end
        bus.wfull = 1'b1;
        wrst = 1'b1;
        #1;
        n_run++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b expected 0000", bus.req_ready); end
        tick();
        exp_cnt = 0;
        n_run++; if (bus.winc !== 1'b0 || bus.wr_count !== 16'd0) begin n_fail++; $display("FAIL mid_reset: got winc %b count %0d expected 0/0", bus.winc, bus.wr_count); end
        wrst = 1'b0;
        bus.wfull = 1'b0;
        #1;
        n_run++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_represent: got %b expected 0001", bus.req_ready); end
        tick();
        n_run++; if (bus.wdata !== 8'h77 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_reload: got data %h id %0d expected 77/0", bus.wdata, bus.grant_id); end
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_pkt();
        int w;
        int exp_g[4];
        logic [NREQ-1:0] rdy;
        if (LOCK_EN) exp_g = '{1, 1, 1, 2};
        else         exp_g = '{1, 2, 0, 1};
        wrst = 1'b1;
        bus.req_valid = 4'h0;
        bus.req_last  = 4'hF;
        tick();
        wrst = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: DSIZE] = 8'h01;
        tick();
        bus.req_valid = 4'h0;
        tick();
        w = 0;
        bus.req_valid = 4'b0111;
        bus.req_data[0 +: DSIZE]       = 8'hA0;
        bus.req_data[2*DSIZE +: DSIZE] = 8'hC0;
        bus.req_data[DSIZE +: DSIZE]   = 8'hB0;
        bus.req_last[1] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            rdy = bus.req_ready;
            tick();
            n_run++; if (bus.grant_id !== 2'(exp_g[s])) begin n_fail++; $display("FAIL pkt_grant[%0d]: got %0d expected %0d", s, bus.grant_id, exp_g[s]); end
            if (rdy[1]) begin
                w++;
                bus.req_data[DSIZE +: DSIZE] = 8'(8'hB0 + w);
                bus.req_last[1] = (w == 2);
                if (w == 3) bus.req_valid[1] = 1'b0;
            end
        end
        bus.req_valid = 4'h0;
        bus.req_last  = 4'hF;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit              m_winc;
        logic [7:0]      m_wdata;
        int              m_gid;
        logic [15:0]     m_cnt;
        int              m_rr;
        bit              m_locked;
        int              m_lock;
        int              pick;
        logic [NREQ-1:0] exp_ready;
        logic [7:0]      pick_data;
        bit              pick_last;
        bit              drain;
        wrst = 1'b1;
        bus.req_valid = 4'h0;
        bus.wfull = 1'b0;
        tick();
        m_winc = 0; m_wdata = 8'h00; m_gid = 0; m_cnt = 16'd0; m_rr = 0; m_locked = 0; m_lock = 0;
        for (int c = 0; c < 600; c++) begin
            wrst = ($urandom_range(0, 63) == 0);
            bus.wfull = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i*DSIZE +: DSIZE] = 8'($urandom);
                    bus.req_last[i] = ($urandom_range(0, 2) != 0);
                end
            end
            #1;
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (pick < 0 && bus.req_valid[i] && (!m_locked || i == m_lock)) pick = i;
            end
            exp_ready = 4'b0000;
            if (pick >= 0 && (!m_winc || !bus.wfull) && !wrst) exp_ready[pick] = 1'b1;
            n_run++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, bus.req_ready, exp_ready); end
            pick_data = (pick >= 0) ? bus.req_data[pick*DSIZE +: DSIZE] : 8'h00;
            pick_last = (pick >= 0) ? bus.req_last[pick] : 1'b0;
            drain = m_winc && !bus.wfull;
            tick();
            if (wrst) begin
                m_winc = 0; m_wdata = 8'h00; m_gid = 0; m_cnt = 16'd0; m_rr = 0; m_locked = 0; m_lock = 0;
            end else begin
                if (drain) m_cnt = m_cnt + 16'd1;
                if (exp_ready != 4'b0000) begin
                    m_winc = 1; m_wdata = pick_data; m_gid = pick;
                    if (!LOCK_EN || pick_last) begin
                        m_rr = (pick + 1) % NREQ;
                        m_locked = 0;
                    end else begin
                        m_locked = 1;
                        m_lock = pick;
                    end
                end else if (drain) begin
                    m_winc = 0;
                end
            end
            n_run++; if (bus.winc !== m_winc) begin n_fail++; $display("FAIL rnd_winc[%0d]: got %b expected %b", c, bus.winc, m_winc); end
            n_run++; if (bus.wdata !== m_wdata || bus.grant_id !== 2'(m_gid)) begin n_fail++; $display("FAIL rnd_slot[%0d]: got %h/%0d expected %h/%0d", c, bus.wdata, bus.grant_id, m_wdata, m_gid); end
            n_run++; if (bus.wr_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, bus.wr_count, m_cnt); end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    initial begin
        bus.req_valid = 4'h0;
        bus.req_data  = 32'h0;
        bus.req_last  = 4'hF;
        bus.wfull     = 1'b0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_midop_reset();
        test_pkt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
